uart_tx_fifo_cfg: RTL

Parametrised UART transmitter with a write-side FIFO. Frame format is selected at run time: 5–8 data bits, none/even/odd parity, and 1 or 2 stop bits. The bit period comes from a run-time divisor instead of fixed baud constants. It sits between a bus or register master and the board TX pin, and sends back-to-back frames with no idle gap while the FIFO holds data.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 56 +++++
 rtl/uart_tx_fifo_cfg.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, TX state enum and frame-size helpers.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Smallest usable divisor; anything below is clamped up to it.
  localparam int MIN_DIV = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  function automatic logic [3:0] data_bits_to_n(input logic [1:0] data_bits);
    return 4'd5 + {2'b00, data_bits};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; rd_data is the head entry whenever empty is low.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push on full still lands.
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with write FIFO and run-time frame format; config is
// shadowed at each frame load so mid-frame changes only affect later frames.
module uart_tx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 434
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic [1:0]                  data_bits,
  input  logic [1:0]                  parity_mode,
  input  logic                        stop_bits,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        tx_busy,
  output logic                        uart_tx,
  output logic                        frame_done,
  output logic [2:0]                  dbg_state
);

  tx_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
  logic [3:0]       nbits_q, nbits_d;
  logic [1:0]       par_q, par_d;
  logic             stop2_q, stop2_d;
  logic [7:0]       data_q, data_d;
  logic [2:0]       idx_q, idx_d;
  logic             stop_cnt_q, stop_cnt_d;
  logic             tx_q, tx_d;

  logic             fifo_empty;
  logic [7:0]       fifo_rd_data;
  logic             load;
  logic             bit_end, last_data, last_stop, par_en;
  logic [3:0]       load_n;
  logic [7:0]       load_mask;
  logic [DIV_W-1:0] load_div;

  // Write side: wr_en is a one-cycle request with no ready; it is taken when
  // the FIFO has room or a pop happens that cycle, otherwise overflow pulses.
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (load),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign overflow  = wr_en && fifo_full && !load;
  assign tx_busy   = (state_q != ST_IDLE);
  assign uart_tx   = tx_q;
  assign dbg_state = state_q;

  assign bit_end   = (cnt_q == div_q - DIV_W'(1));
  assign last_data = ({1'b0, idx_q} == nbits_q - 4'd1);
  assign last_stop = (stop_cnt_q == stop2_q);
  assign par_en    = (par_q != PAR_NONE);
  assign load_n    = data_bits_to_n(data_bits);
  assign load_div  = (baud_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : baud_div;

  // Unused upper data bits are cleared at load so parity is a plain XOR.
  always_comb begin
    load_mask = '0;
    for (int i = 0; i < 8; i++) load_mask[i] = (i < int'(load_n));
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    data_d     = data_q;
    div_d      = div_q;
    nbits_d    = nbits_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    load       = 1'b0;
    frame_done = 1'b0;

    if (state_q != ST_IDLE) cnt_d = bit_end ? '0 : cnt_q + DIV_W'(1);

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) load = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
          tx_d    = data_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (!last_data) begin
            idx_d = idx_q + 3'd1;
            tx_d  = data_q[idx_q + 3'd1];
          end else if (par_en) begin
            state_d = ST_PARITY;
            tx_d    = (^data_q) ^ (par_q == PAR_ODD);
          end else begin
            state_d    = ST_STOP;
            stop_cnt_d = 1'b0;
            tx_d       = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            frame_done = 1'b1;
            if (!fifo_empty) load = 1'b1;
            else state_d = ST_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame load from IDLE or straight out of the last stop bit.
    if (load) begin
      state_d = ST_START;
      cnt_d   = '0;
      tx_d    = 1'b0;
      data_d  = fifo_rd_data & load_mask;
      div_d   = load_div;
      nbits_d = load_n;
      par_d   = (parity_mode == PAR_EVEN || parity_mode == PAR_ODD) ? parity_mode : PAR_NONE;
      stop2_d = stop_bits;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      data_q     <= '0;
      div_q      <= DIV_W'(DEFAULT_DIV);
      nbits_q    <= 4'd8;
      par_q      <= PAR_NONE;
      stop2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      data_q     <= data_d;
      div_q      <= div_d;
      nbits_q    <= nbits_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
    end
  end

endmodule
